// File: rtl/sfifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_param_if
//  Description : Handshake/data bundle for the sfifo_param synchronous FIFO.
//                The master side (producer/consumer agent) drives data_in,
//                push and pop. The slave side (the FIFO) returns read data,
//                the status flags, the occupancy count and the error pulses.
//  Signals     : data_in[DATA_W], push, pop           (master -> slave)
//                data_out[DATA_W], full, empty,
//                almost_full, almost_empty,
//                count[$clog2(DEPTH)+1], overflow,
//                underflow                            (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface sfifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, push, pop,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sfifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_param
//  Description : Single-clock parametrised FIFO with programmable almost
//                thresholds, occupancy count, registered overflow/underflow
//                pulses and selectable registered or first-word-fall-through
//                read data.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - sfifo_param_if.slave (data_in/push/pop in;
//                       data_out/flags/count/error pulses out)
//  Revision    : 1.0  initial release
// ============================================================================
module sfifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  wire          clk,
  input  wire          rst,
  sfifo_param_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;

  // Flags come only from the registered count: no push/pop combinational path.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok  = bus.pop  & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    overflow_d  = bus.push & ~push_ok;
    underflow_d = bus.pop  & ~pop_ok;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not cleared by reset; a write is suppressed while
  // reset is asserted so reset dominates a concurrent push.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // Read data. When full with push+pop both pointers address the same slot;
  // both read styles return the old head word because the write only lands
  // at the edge.
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (pop_ok) begin
          rdata_q <= mem_q[rd_ptr_q];
        end
      end
      assign bus.data_out = rdata_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfifo_param
//  Description : Directed self-checking bench for sfifo_param. One instance
//                uses registered reads, a second uses first-word-fall-through.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sfifo_param;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sfifo_param_if #(.DATA_W(8), .DEPTH(16)) bus0 ();
  sfifo_param_if #(.DATA_W(8), .DEPTH(16)) bus1 ();

  sfifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sfifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed and outputs
  // sampled at this point, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.push = 1'b1; bus0.pop = 1'b0; bus0.data_in = 8'h77;
    bus1.push = 1'b1; bus1.pop = 1'b0; bus1.data_in = 8'h77;
    step();
    step();
    n_tests++;
    if (bus0.count !== 5'd0) begin
      n_fail++; $display("FAIL reset_count got %0d exp 0", bus0.count);
    end
    n_tests++;
    if (bus0.empty !== 1'b1 || bus0.almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty got e=%b ae=%b exp e=1 ae=1", bus0.empty, bus0.almost_empty);
    end
    n_tests++;
    if (bus0.full !== 1'b0 || bus0.almost_full !== 1'b0 || bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got f=%b af=%b ov=%b un=%b exp all 0",
                         bus0.full, bus0.almost_full, bus0.overflow, bus0.underflow);
    end
    n_tests++;
    if (bus0.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout got %h exp 00", bus0.data_out);
    end
    n_tests++;
    if (bus1.count !== 5'd0 || bus1.empty !== 1'b1 || bus1.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_fwft got cnt=%0d e=%b d=%h exp cnt=0 e=1 d=00",
                         bus1.count, bus1.empty, bus1.data_out);
    end
    rst = 1'b0;
    bus0.push = 1'b0;
    bus1.push = 1'b0;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      bus0.push = 1'b1; bus0.data_in = 8'(i);
      step();
      n_tests++;
      if (bus0.count !== 5'(i + 1) || bus0.full !== ((i + 1) == 16) ||
          bus0.almost_full !== ((i + 1) >= 12) || bus0.almost_empty !== ((i + 1) <= 4) ||
          bus0.empty !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d got cnt=%0d f=%b af=%b ae=%b e=%b exp cnt=%0d",
                           i, bus0.count, bus0.full, bus0.almost_full, bus0.almost_empty,
                           bus0.empty, i + 1);
      end
    end
    bus0.data_in = 8'hFF;
    step();
    n_tests++;
    if (bus0.overflow !== 1'b1 || bus0.count !== 5'd16) begin
      n_fail++; $display("FAIL overflow_pulse got ov=%b cnt=%0d exp ov=1 cnt=16", bus0.overflow, bus0.count);
    end
    bus0.push = 1'b0;
    step();
    n_tests++;
    if (bus0.overflow !== 1'b0 || bus0.count !== 5'd16) begin
      n_fail++; $display("FAIL overflow_clear got ov=%b cnt=%0d exp ov=0 cnt=16", bus0.overflow, bus0.count);
    end
    for (int i = 0; i < 16; i++) begin
      bus0.pop = 1'b1;
      step();
      n_tests++;
      if (bus0.data_out !== 8'(i) || bus0.count !== 5'(15 - i)) begin
        n_fail++; $display("FAIL drain_%0d got d=%h cnt=%0d exp d=%h cnt=%0d",
                           i, bus0.data_out, bus0.count, 8'(i), 15 - i);
      end
    end
    bus0.pop = 1'b0;
    step();
    n_tests++;
    if (bus0.empty !== 1'b1 || bus0.data_out !== 8'h0F) begin
      n_fail++; $display("FAIL drain_end got e=%b d=%h exp e=1 d=0f", bus0.empty, bus0.data_out);
    end
  endtask

  task automatic test_underflow();
    bus0.pop = 1'b1;
    step();
    n_tests++;
    if (bus0.underflow !== 1'b1 || bus0.data_out !== 8'h0F || bus0.count !== 5'd0) begin
      n_fail++; $display("FAIL underflow_pulse got un=%b d=%h cnt=%0d exp un=1 d=0f cnt=0",
                         bus0.underflow, bus0.data_out, bus0.count);
    end
    bus0.pop = 1'b0;
    step();
    n_tests++;
    if (bus0.underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear got un=%b exp 0", bus0.underflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      bus0.push = 1'b1; bus0.data_in = 8'h20 + 8'(i);
      step();
    end
    bus0.pop = 1'b1; bus0.data_in = 8'h30;
    step();
    n_tests++;
    if (bus0.count !== 5'd16 || bus0.overflow !== 1'b0 || bus0.data_out !== 8'h20) begin
      n_fail++; $display("FAIL full_pushpop got cnt=%0d ov=%b d=%h exp cnt=16 ov=0 d=20",
                         bus0.count, bus0.overflow, bus0.data_out);
    end
    bus0.push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if (bus0.data_out !== 8'h21 + 8'(i)) begin
        n_fail++; $display("FAIL order_%0d got %h exp %h", i, bus0.data_out, 8'h21 + 8'(i));
      end
    end
    bus0.push = 1'b1; bus0.data_in = 8'h55;
    step();
    n_tests++;
    if (bus0.count !== 5'd1 || bus0.underflow !== 1'b1 || bus0.overflow !== 1'b0) begin
      n_fail++; $display("FAIL empty_pushpop got cnt=%0d un=%b ov=%b exp cnt=1 un=1 ov=0",
                         bus0.count, bus0.underflow, bus0.overflow);
    end
    bus0.push = 1'b0;
    step();
    n_tests++;
    if (bus0.data_out !== 8'h55 || bus0.count !== 5'd0) begin
      n_fail++; $display("FAIL empty_pushpop_read got d=%h cnt=%0d exp d=55 cnt=0", bus0.data_out, bus0.count);
    end
    bus0.pop = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] wdata;
    logic       p, r, pop_ok, push_ok;
    exp_d = 8'h55;
    for (int i = 0; i < 40; i++) begin
      p     = ($urandom_range(0, 9) < 7);
      r     = ($urandom_range(0, 9) < 5);
      wdata = 8'($urandom);
      pop_ok  = r && (q.size() > 0);
      push_ok = p && ((q.size() < 16) || pop_ok);
      if (pop_ok) exp_d = q.pop_front();
      if (push_ok) q.push_back(wdata);
      bus0.push = p; bus0.pop = r; bus0.data_in = wdata;
      step();
      n_tests++;
      if (bus0.data_out !== exp_d || bus0.count !== 5'(q.size()) ||
          bus0.underflow !== (r && !pop_ok) || bus0.overflow !== (p && !push_ok)) begin
        n_fail++; $display("FAIL wrap_%0d got d=%h cnt=%0d un=%b ov=%b exp d=%h cnt=%0d un=%b ov=%b",
                           i, bus0.data_out, bus0.count, bus0.underflow, bus0.overflow,
                           exp_d, q.size(), r && !pop_ok, p && !push_ok);
      end
    end
    bus0.push = 1'b0; bus0.pop = 1'b0;
  endtask

  task automatic test_fwft();
    bus1.push = 1'b1; bus1.data_in = 8'hA5;
    step();
    bus1.push = 1'b0;
    n_tests++;
    if (bus1.data_out !== 8'hA5 || bus1.empty !== 1'b0) begin
      n_fail++; $display("FAIL fwft_visible got d=%h e=%b exp d=a5 e=0", bus1.data_out, bus1.empty);
    end
    step();
    n_tests++;
    if (bus1.data_out !== 8'hA5 || bus1.count !== 5'd1) begin
      n_fail++; $display("FAIL fwft_hold got d=%h cnt=%0d exp d=a5 cnt=1", bus1.data_out, bus1.count);
    end
    bus1.pop = 1'b1;
    step();
    bus1.pop = 1'b0;
    n_tests++;
    if (bus1.empty !== 1'b1 || bus1.count !== 5'd0 || bus1.data_out !== 8'h00) begin
      n_fail++; $display("FAIL fwft_pop got e=%b cnt=%0d d=%h exp e=1 cnt=0 d=00",
                         bus1.empty, bus1.count, bus1.data_out);
    end
    for (int i = 0; i < 5; i++) begin
      bus1.push = 1'b1; bus1.data_in = 8'hB0 + 8'(i);
      step();
    end
    bus1.push = 1'b0;
    n_tests++;
    if (bus1.count !== 5'd5 || bus1.data_out !== 8'hB0) begin
      n_fail++; $display("FAIL fwft_head got cnt=%0d d=%h exp cnt=5 d=b0", bus1.count, bus1.data_out);
    end
    bus1.pop = 1'b1;
    step();
    bus1.pop = 1'b0;
    n_tests++;
    if (bus1.count !== 5'd4 || bus1.data_out !== 8'hB1) begin
      n_fail++; $display("FAIL fwft_next got cnt=%0d d=%h exp cnt=4 d=b1", bus1.count, bus1.data_out);
    end
    bus1.push = 1'b1; bus1.data_in = 8'hEE;
    step();
    bus1.push = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus1.empty !== 1'b1 || bus1.count !== 5'd0 || bus1.data_out !== 8'h00) begin
      n_fail++; $display("FAIL fwft_reset got e=%b cnt=%0d d=%h exp e=1 cnt=0 d=00",
                         bus1.empty, bus1.count, bus1.data_out);
    end
    n_tests++;
    if (bus0.empty !== 1'b1 || bus0.count !== 5'd0 || bus0.data_out !== 8'h00) begin
      n_fail++; $display("FAIL midstream_reset got e=%b cnt=%0d d=%h exp e=1 cnt=0 d=00",
                         bus0.empty, bus0.count, bus0.data_out);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus0.push = 1'b0; bus0.pop = 1'b0; bus0.data_in = 8'h00;
    bus1.push = 1'b0; bus1.pop = 1'b0; bus1.data_in = 8'h00;
    #2;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_wrap();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
